// File: rtl/hazard_sched_ctrl_pkg.sv
// Shared types for the RV32 pipeline hazard scheduler: FSM states, the
// per-cycle pipeline control bundle and the flush countdown helper.
package hazard_sched_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HAZ   = 2'd1,
        MEMW  = 2'd2,
        FLUSH = 2'd3
    } hazard_state_t;

    typedef struct packed {
        logic stall_front;
        logic bubble_ex;
        logic stall_back;
        logic flush_if;
    } haz_ctrl_t;

    // Flush squash lasts at most 3 cycles, so the countdown fits in 2 bits.
    localparam int FlushCntWidth = 2;

    localparam haz_ctrl_t HAZ_CTRL_IDLE = '0;

    function automatic logic [FlushCntWidth-1:0] flush_reload(input int cycles);
        return FlushCntWidth'(cycles - 1);
    endfunction

endpackage

// File: rtl/hazard_sched_ctrl_reg_scoreboard.sv
// Per-register in-flight write counters; reports which registers have an
// outstanding write and whether the destination counter is full.
module reg_scoreboard #(
    parameter int RegAddrWidth = 5,
    parameter int CntWidth     = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           issue_en_i,
    input  logic [RegAddrWidth-1:0]        issue_addr_i,
    input  logic                           retire_en_i,
    input  logic [RegAddrWidth-1:0]        retire_addr_i,
    input  logic [RegAddrWidth-1:0]        rs1_addr_i,
    input  logic [RegAddrWidth-1:0]        rs2_addr_i,
    input  logic [RegAddrWidth-1:0]        rd_addr_i,
    output logic [(1<<RegAddrWidth)-1:0]   pending_o,
    output logic                           rs1_pending_o,
    output logic                           rs2_pending_o,
    output logic                           sat_o
);
    localparam int NumRegs = 1 << RegAddrWidth;
    localparam logic [CntWidth-1:0] CntMax = {CntWidth{1'b1}};

    logic [CntWidth-1:0] cnt_q [NumRegs];
    logic [CntWidth-1:0] cnt_d [NumRegs];
    logic [NumRegs-1:0]  inc_vec;
    logic [NumRegs-1:0]  dec_vec;

    assign inc_vec = issue_en_i  ? (NumRegs'(1) << issue_addr_i)  : '0;
    assign dec_vec = retire_en_i ? (NumRegs'(1) << retire_addr_i) : '0;

    // Issue and retire on the same register cancel; retire of an idle register is dropped.
    always_comb begin
        for (int r = 0; r < NumRegs; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r] && (cnt_q[r] != CntMax)) begin
                cnt_d[r] = cnt_q[r] + 1'b1;
            end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NumRegs; r++) begin
            if (!rst_ni) begin
                cnt_q[r] <= '0;
            end else begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NumRegs; r++) begin
            pending_o[r] = (cnt_q[r] != '0);
        end
    end

    assign rs1_pending_o = pending_o[rs1_addr_i];
    assign rs2_pending_o = pending_o[rs2_addr_i];
    assign sat_o         = (cnt_q[rd_addr_i] == CntMax);

endmodule

// File: rtl/hazard_sched_ctrl.sv
// Pipeline scheduler beside ID: RAW/saturation hazards, memory-wait freeze and
// redirect flush sequencing for the IF/ID/EX pipeline registers.
module hazard_sched_ctrl
    import hazard_sched_ctrl_pkg::*;
#(
    parameter int RegAddrWidth = 5,
    parameter int CntWidth     = 2,
    parameter int FlushCycles  = 1,
    parameter int PerfWidth    = 32
) (
    input  logic                          iClk,
    input  logic                          nRst,
    input  logic                          iIdValid,
    input  logic                          iIdRs1En,
    input  logic                          iIdRs2En,
    input  logic [RegAddrWidth-1:0]       iIdRs1Addr,
    input  logic [RegAddrWidth-1:0]       iIdRs2Addr,
    input  logic                          iIdRdEn,
    input  logic [RegAddrWidth-1:0]       iIdRdAddr,
    input  logic                          iIdBrTrue,
    input  logic                          iMemBusy,
    input  logic                          iWbEn,
    input  logic [RegAddrWidth-1:0]       iWbAddr,
    output logic                          oStallFront,
    output logic                          oBubbleEX,
    output logic                          oStallBack,
    output logic                          oFlushIF,
    output logic [(1<<RegAddrWidth)-1:0]  oPending,
    output logic [1:0]                    oState,
    output logic [PerfWidth-1:0]          oStallCnt
);
    localparam int NumRegs = 1 << RegAddrWidth;
    localparam logic [FlushCntWidth-1:0] FlushReload = flush_reload(FlushCycles);
    localparam bit FlushMulti = (FlushCycles > 1);

    hazard_state_t              state_q, state_d;
    logic [FlushCntWidth-1:0]   flush_cnt_q, flush_cnt_d;
    logic [PerfWidth-1:0]       stall_cnt_q, stall_cnt_d;
    logic                       init_q;

    logic                       active;
    logic                       mem_busy;
    logic                       raw;
    logic                       sat;
    logic                       hazard;
    logic                       stall_front;
    logic                       accept;
    logic                       issue;
    logic                       retire;
    logic [NumRegs-1:0]         pending;
    logic                       rs1_pending;
    logic                       rs2_pending;
    logic                       sb_sat;
    haz_ctrl_t                  ctrl;

    // Control is held quiet during reset and for the first cycle out of it.
    assign active      = nRst & ~init_q;
    assign raw         = active & iIdValid & ((iIdRs1En & rs1_pending) | (iIdRs2En & rs2_pending));
    assign sat         = active & iIdValid & iIdRdEn & sb_sat;
    assign hazard      = raw | sat;
    assign mem_busy    = active & iMemBusy;
    assign stall_front = mem_busy | hazard;
    assign accept      = active & iIdValid & iIdBrTrue & ~stall_front;

    assign issue  = iIdValid & iIdRdEn & (iIdRdAddr != '0) & ~ctrl.stall_front & ~ctrl.stall_back;
    assign retire = iWbEn & (iWbAddr != '0) & ~ctrl.stall_back;

    reg_scoreboard #(
        .RegAddrWidth (RegAddrWidth),
        .CntWidth     (CntWidth)
    ) u_scoreboard (
        .clk_i         (iClk),
        .rst_ni        (nRst),
        .issue_en_i    (issue),
        .issue_addr_i  (iIdRdAddr),
        .retire_en_i   (retire),
        .retire_addr_i (iWbAddr),
        .rs1_addr_i    (iIdRs1Addr),
        .rs2_addr_i    (iIdRs2Addr),
        .rd_addr_i     (iIdRdAddr),
        .pending_o     (pending),
        .rs1_pending_o (rs1_pending),
        .rs2_pending_o (rs2_pending),
        .sat_o         (sb_sat)
    );

    always_ff @(posedge iClk) begin
        if (!nRst) begin
            init_q      <= 1'b1;
            state_q     <= RUN;
            flush_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            init_q      <= 1'b0;
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A memory wait freezes the flush countdown; it resumes in FLUSH on release.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (mem_busy) begin
            state_d = MEMW;
        end else if (accept && FlushMulti) begin
            state_d     = FLUSH;
            flush_cnt_d = FlushReload;
        end else begin
            case (state_q)
                RUN, HAZ: state_d = hazard ? HAZ : RUN;
                MEMW: begin
                    if (flush_cnt_q != '0) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = hazard ? HAZ : RUN;
                    end
                end
                FLUSH: begin
                    if (!hazard) begin
                        if (flush_cnt_q <= FlushCntWidth'(1)) begin
                            flush_cnt_d = '0;
                            state_d     = RUN;
                        end else begin
                            flush_cnt_d = flush_cnt_q - 1'b1;
                        end
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        ctrl = HAZ_CTRL_IDLE;
        if (mem_busy) begin
            ctrl.stall_back  = 1'b1;
            ctrl.stall_front = 1'b1;
        end else if (hazard) begin
            ctrl.stall_front = 1'b1;
            ctrl.bubble_ex   = 1'b1;
        end else begin
            ctrl.flush_if = accept | ((state_q == FLUSH) & (flush_cnt_q != '0));
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ctrl.stall_front && (stall_cnt_q != {PerfWidth{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign oStallFront = ctrl.stall_front;
    assign oBubbleEX   = ctrl.bubble_ex;
    assign oStallBack  = ctrl.stall_back;
    assign oFlushIF    = ctrl.flush_if;
    assign oPending    = active ? pending : '0;
    assign oState      = state_q;
    assign oStallCnt   = stall_cnt_q;

endmodule

// File: doc/hazard_sched_ctrl.md
Name: hazard_sched_ctrl

Overview:
Central pipeline scheduler for the 5-stage RV32 core.
- Tracks in-flight register writes in a per-register scoreboard.
- Detects RAW hazards for the instruction in ID, and sequences stall, bubble and flush for IF/ID/EX.
- Freezes the back end while data memory is busy.
- Sits beside the ID stage and drives the stall/flush inputs of every pipeline register.

Parameters:
RegAddrWidth, 5, register address width (from rv32_isa)
CntWidth, 2, per-register in-flight write counter width (max 2^CntWidth-1 outstanding writes)
FlushCycles, 1, cycles of IF squash after an accepted redirect (1..3)
PerfWidth, 32, stall-cycle performance counter width

Ports:
iClk  in  1  clock, rising edge
nRst  in  1  synchronous active-low reset
iIdValid  in  1  ID holds a valid instruction
iIdRs1En, iIdRs2En  in  1  source operand used
iIdRs1Addr, iIdRs2Addr  in  RegAddrWidth  source addresses
iIdRdEn  in  1  instruction writes rd
iIdRdAddr  in  RegAddrWidth  destination address
iIdBrTrue  in  1  ID resolved a taken branch/jump
iMemBusy  in  1  data memory not ready (MEM stage must hold)
iWbEn  in  1  WB stage retires a register write this cycle
iWbAddr  in  RegAddrWidth  retiring rd
oStallFront  out  1  hold PC, IF/ID register
oBubbleEX  out  1  load NOP (valid=0) into ID/EX
oStallBack  out  1  hold ID/EX, EX/MEM, MEM/WB
oFlushIF  out  1  squash IF/ID contents (valid=0)
oPending  out  2^RegAddrWidth  per-register pending mask (count != 0)
oState  out  2  current FSM state (debug)
oStallCnt  out  PerfWidth  saturating count of cycles with oStallFront=1

Behaviour:
- Clock iClk; reset nRst is synchronous, active-low. While nRst=0 at a rising edge:
  - all counters clear to 0; state goes to RUN; flush countdown clears; oStallCnt clears.
- Outputs during reset and the cycle after: oStallFront=oBubbleEX=oStallBack=oFlushIF=0, oPending=0.
- Scoreboard:
  - cnt[r] per register; x0 is never incremented and always reads 0.
  - issue = iIdValid & iIdRdEn & iIdRdAddr!=0 & ~oStallFront & ~oStallBack.
  - retire = iWbEn & iWbAddr!=0 & ~oStallBack.
  - issue only: cnt+1. retire only: cnt-1. Both on the same register: unchanged.
  - retire with cnt=0: ignored (no underflow).
- raw = iIdValid & ((iIdRs1En & cnt[rs1]!=0) | (iIdRs2En & cnt[rs2]!=0)). Same-cycle retire of rs does NOT clear raw; WB bypass is out of scope.
- sat = iIdValid & iIdRdEn & cnt[rd] at max. sat is treated as a hazard.
- Combinational outputs, priority highest first:
  - iMemBusy: oStallBack=1, oStallFront=1, oBubbleEX=0, oFlushIF=0.
  - raw|sat: oStallFront=1, oBubbleEX=1.
  - Otherwise no stall.
- Redirect accepted when iIdBrTrue & iIdValid & ~oStallFront & ~oStallBack.
  - oFlushIF=1 in the accept cycle and for FlushCycles-1 further non-stalled cycles.
  - Redirect is ignored while the front end is stalled; ID re-presents it later.
- FSM (registered, next-state from the same conditions):
  - RUN(0): ->MEMW on iMemBusy; ->HAZ on raw|sat; ->FLUSH on accepted redirect with FlushCycles>1.
  - HAZ(1): ->MEMW on iMemBusy; stay while raw|sat; else RUN.
  - MEMW(2): stay while iMemBusy; on release go to HAZ if raw|sat, else RUN.
  - FLUSH(3): decrement the countdown each non-stalled cycle; ->RUN at 0; MEMW preempts and the countdown is frozen.
- A redirect accepted in FLUSH reloads the countdown.
- oStallCnt increments when oStallFront=1; saturates at all-ones.

Decomposition:
- pipeline_types additions:
  - hazard_state_t enum {RUN, HAZ, MEMW, FLUSH}.
  - haz_ctrl_t struct {stall_front, bubble_ex, stall_back, flush_if}.
- Sub-module reg_scoreboard:
  - holds the counter array.
  - inputs: issue/retire address+enable; read ports rs1/rs2/rd.
  - outputs: pending mask, sat flag.
- Top handles the FSM, priority and perf counter.

Test Plan:
- Reset: nRst=0 for 2 cycles with random inputs -> all outputs 0, oPending=0, oState=RUN, oStallCnt=0.
- RAW: issue rd=x5; next cycle ID rs1=x5 -> oStallFront=oBubbleEX=1 until iWbEn with iWbAddr=5; released the cycle after retire; oStallCnt=3 for a 3-cycle gap.
- x0 and same-cycle: issue rd=x0 -> oPending=0. Issue rd=x7 while retiring x7 with cnt=1 -> cnt stays 1, oPending[7]=1.
- Saturation (CntWidth=2): 3 issues to x9 without retire -> a 4th write to x9 stalls; one retire -> issue proceeds.
- Redirect (FlushCycles=2): iIdBrTrue accepted -> oFlushIF=1 for 2 cycles, state FLUSH then RUN. With raw=1 the same cycle -> no flush, stall instead.
- Mem wait: iMemBusy=1 for 4 cycles during FLUSH -> oStallBack=oStallFront=1, oBubbleEX=0, flush countdown frozen; resumes FLUSH, then RUN.
